// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Default 640x480@60 timing constants and axis/sync-window helpers.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int POS_W = 10;
    localparam int MAX_TOTAL = 1 << POS_W;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef logic [POS_W-1:0] pos_t;

    function automatic int axis_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int h_total(input int disp, input int front,
                                   input int sync, input int back);
        return axis_total(disp, front, sync, back);
    endfunction

    function automatic int v_total(input int disp, input int front,
                                   input int sync, input int back);
        return axis_total(disp, front, sync, back);
    endfunction

    function automatic int sync_first(input int disp, input int front);
        return disp + front;
    endfunction

    function automatic int sync_end(input int disp, input int front, input int sync);
        return disp + front + sync;
    endfunction

    // Bounds are one bit wider than a position so an exclusive end of 1024 fits.
    function automatic logic in_window(input pos_t pos,
                                       input logic [POS_W:0] lo,
                                       input logic [POS_W:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : Wrapping 0..TOTAL-1 counter with enable, terminal count and
//            next-value output for zero-skew decode in the parent.
// Revision : 1.0
// ============================================================================
module vga_axis_counter #(
    parameter int WIDTH = 10,
    parameter int TOTAL = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;

    assign w_tc = (r_count == c_LAST);

    always_comb begin
        w_next = r_count;
        if (i_en) begin
            w_next = w_tc ? '0 : r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
    assign o_next  = w_next;
    assign o_tc    = w_tc;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA pixel timing: positions, syncs, display enable, line/frame/
//            vsync strobes and frame counter, all registered with zero skew.
// Revision : 1.0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY       = DEF_H_DISPLAY,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_DISPLAY       = DEF_V_DISPLAY,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int FRAME_W         = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic               vsync_start,
    output logic [FRAME_W-1:0] frame_no
);

    localparam int c_H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int c_V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [POS_W:0] c_H_DISP = (POS_W+1)'(H_DISPLAY);
    localparam logic [POS_W:0] c_V_DISP = (POS_W+1)'(V_DISPLAY);
    localparam logic [POS_W:0] c_HS_LO  = (POS_W+1)'(sync_first(H_DISPLAY, H_FRONT));
    localparam logic [POS_W:0] c_HS_HI  = (POS_W+1)'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [POS_W:0] c_VS_LO  = (POS_W+1)'(sync_first(V_DISPLAY, V_FRONT));
    localparam logic [POS_W:0] c_VS_HI  = (POS_W+1)'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));
    localparam pos_t           c_VS_FIRST = POS_W'(sync_first(V_DISPLAY, V_FRONT));
    localparam logic           c_SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    if (c_H_TOTAL > MAX_TOTAL || c_V_TOTAL > MAX_TOTAL) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 10-bit counters",
               c_H_TOTAL, c_V_TOTAL);
    end

    pos_t w_h_next;
    pos_t w_v_next;
    logic w_h_tc;
    logic w_v_tc;
    logic w_v_en;
    logic w_line_wrap;
    logic w_frame_wrap;
    logic w_vs_first;
    logic w_hs_active;
    logic w_vs_active;
    logic w_disp_next;

    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;
    logic               r_line_start;
    logic               r_frame_start;
    logic               r_vsync_start;
    logic [FRAME_W-1:0] r_frame_no;

    assign w_v_en = pix_en & w_h_tc;

    vga_axis_counter #(
        .WIDTH (POS_W),
        .TOTAL (c_H_TOTAL)
    ) u_h_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (pix_en),
        .o_count (hpos),
        .o_next  (w_h_next),
        .o_tc    (w_h_tc)
    );

    vga_axis_counter #(
        .WIDTH (POS_W),
        .TOTAL (c_V_TOTAL)
    ) u_v_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_v_en),
        .o_count (vpos),
        .o_next  (w_v_next),
        .o_tc    (w_v_tc)
    );

    // Flags are decoded from the counters' next values so they land on the
    // same edge as the positions they describe.
    assign w_line_wrap  = w_v_en;
    assign w_frame_wrap = w_line_wrap & w_v_tc;
    assign w_vs_first   = w_line_wrap && (w_v_next == c_VS_FIRST);
    assign w_hs_active  = in_window(w_h_next, c_HS_LO, c_HS_HI);
    assign w_vs_active  = in_window(w_v_next, c_VS_LO, c_VS_HI);
    assign w_disp_next  = ({1'b0, w_h_next} < c_H_DISP) && ({1'b0, w_v_next} < c_V_DISP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync       <= c_SYNC_IDLE;
            r_vsync       <= c_SYNC_IDLE;
            r_display_on  <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vsync_start <= 1'b0;
            r_frame_no    <= '0;
        end else begin
            r_hsync       <= w_hs_active ^ c_SYNC_IDLE;
            r_vsync       <= w_vs_active ^ c_SYNC_IDLE;
            r_display_on  <= w_disp_next;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
            r_vsync_start <= w_vs_first;
            if (w_frame_wrap) begin
                r_frame_no <= r_frame_no + FRAME_W'(1);
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign vsync_start = r_vsync_start;
    assign frame_no    = r_frame_no;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing source for the VGA demo path: generates hpos/vpos, hsync/vsync and display_on for the colour stage and the Tiny VGA Pmod pin mapping.
- Also produces single-cycle line/frame/vsync strobes and a frame counter.
- Downstream logic stays in the clk domain; nothing needs to clock on vsync.
- Default timing is 640x480@60 with a 25.175 MHz pixel clock.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = syncs driven low while active
- FRAME_W, 9, frame_no width

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel advance enable; tie 1 for one pixel per clk
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_on  out  1  high while hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  out  1  one-clk pulse when hpos wraps to 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) wraps to (0,0)
- vsync_start  out  1  one-clk pulse on the first pixel of the first sync line
- frame_no  out  FRAME_W  frames completed since reset, modulo 2^FRAME_W

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Derived constants: H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL similarly (525).
- Registered outputs: every output is a register. All outputs update on the same edge, and the decode flags always describe the hpos/vpos presented in the same cycle, i.e. zero skew.
  - Implementation decodes from next-state counter values.
- Reset (reset=1 at a clk edge) loads, regardless of pix_en:
  - hpos=0, vpos=0, display_on=1
  - hsync/vsync inactive (1 if SYNC_ACTIVE_LOW)
  - line_start, frame_start, vsync_start = 0
  - frame_no=0
- Advance (edge with reset=0, pix_en=1):
  - hpos increments. At H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos at V_TOTAL-1 with an hpos wrap goes to 0.
- Hold (pix_en=0): hpos, vpos, syncs, display_on and frame_no hold. All three strobes are 0 in the following cycle, so each strobe lasts exactly one clk.
- hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), for all hpos of those lines.
- line_start=1 in the cycle following an advance that wrapped hpos to 0. frame_start=1 additionally when vpos also wrapped to 0.
- Reset is not a wrap: no strobe is asserted after reset release.
- frame_no increments on the advance that produces frame_start, so it shows its new value in the same cycle as frame_start. Wraps 2^FRAME_W-1 -> 0 silently.
- vsync_start=1 in the cycle where (hpos,vpos)=(0,V_DISPLAY+V_FRONT) is first presented after an advance.
- Reset mid-frame: the next cycle shows the reset state and counting restarts from (0,0). No partial strobes.
- Widths: counters are 10 bits. Parameters giving H_TOTAL or V_TOTAL > 1024 are illegal, and an elaboration-time check flags them.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480 timing constants
  - H_TOTAL/V_TOTAL helper functions
  - sync-window helper functions
- One sub-module, vga_axis_counter: wrapping counter with enable, terminal-count output and next-value output.
  - Instantiated twice: h, and v enabled by h terminal count.

Test Plan:
- Reset, then pix_en=1 for 801 clks -> hpos 0..799 then 0; vpos 0->1 at clk 800; line_start=1 only in that cycle; frame_start=0.
- Scan line 0 -> hsync active exactly hpos 656..751 (96 clks); display_on=0 exactly hpos 640..799.
- Run 420000 clks -> vsync active for vpos 490..491 (1600 clks); vsync_start once at (0,490); frame_start once at (0,0) with frame_no=1.
- pix_en alternating 1,0 -> hpos sequence unchanged, period doubled; each strobe high exactly one clk; no change while pix_en=0.
- Assert reset for 1 clk at (700,300) with hsync active -> next cycle (0,0), syncs inactive, display_on=1, frame_no=0, no strobes.
- Parameters H 4/1/1/1, V 2/1/1/1, FRAME_W=9, run 512 frames -> frame_no 511->0 wrap coincident with frame_start.
